// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial-pattern detector: state sizing,
// Gray encoding and the elaboration-time transition function.
package seq_det_pkg;

    localparam int MAX_PATTERN_W = 16;

    function automatic int st_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [15:0] gray(input logic [15:0] x);
        return x ^ (x >> 1);
    endfunction

    // Longest pattern prefix that is a suffix of (first st pattern bits, then din).
    // In non-overlap mode the full-match state behaves like idle.
    function automatic int next_state(input int st, input logic din,
                                      input logic [15:0] pattern, input int w,
                                      input bit overlap);
        int   base;
        int   len;
        int   res;
        int   pos;
        logic ok;
        logic c;
        base = (st >= w && !overlap) ? 0 : st;
        len  = base + 1;
        res  = 0;
        for (int k = 1; k <= MAX_PATTERN_W; k++) begin
            if (k <= len && k <= w) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PATTERN_W; j++) begin
                    if (j < k) begin
                        pos = len - k + j;
                        if (pos == base) begin
                            c = din;
                        end else begin
                            c = pattern[w - 1 - pos];
                        end
                        if (c != pattern[w - 1 - j]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Strobe/data inputs and display-path outputs of the pattern detector.
interface seq_detector_param_if #(
    parameter int COUNT_W = 8,
    parameter int ST_W    = 3
);
    logic               enable;
    logic               din;
    logic               clear;
    logic               match;
    logic [COUNT_W-1:0] count;
    logic               sat;
    logic [ST_W-1:0]    state_gray;

    modport master (
        output enable, din, clear,
        input  match, count, sat, state_gray
    );

    modport slave (
        input  enable, din, clear,
        output match, count, sat, state_gray
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating match counter; a synchronous clear takes priority over an increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] q,
    output logic         sat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q + 1'b1;
        end
    end

    // Once all-ones the counter stops, so the flag stays up until clear or reset.
    assign sat = &q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with elaboration-time KMP transition table,
// saturating match counter and Gray-coded state for the display driver.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1100,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   COUNT_W   = 8,
    localparam int                  ST_W      = st_width(PATTERN_W)
) (
    input logic                clk,
    input logic                rst,
    seq_detector_param_if.slave bus
);

    // state             | meaning
    // S_IDLE (0)        | no pattern prefix pending
    // 1..PATTERN_W-1    | that many leading pattern bits received
    // S_MATCH (W)       | whole pattern received, match asserted
    typedef enum logic [ST_W-1:0] {
        S_IDLE  = '0,
        S_MATCH = ST_W'(PATTERN_W)
    } state_t;

    if (PATTERN_W < 2 || PATTERN_W > MAX_PATTERN_W) begin : g_bad_width
        $error("seq_detector_param: PATTERN_W must be within 2..16");
    end

    logic [ST_W-1:0] nxt0 [PATTERN_W+1];
    logic [ST_W-1:0] nxt1 [PATTERN_W+1];

    for (genvar s = 0; s <= PATTERN_W; s++) begin : g_rom
        localparam logic [ST_W-1:0] N0 =
            ST_W'(next_state(s, 1'b0, 16'(PATTERN), PATTERN_W, OVERLAP));
        localparam logic [ST_W-1:0] N1 =
            ST_W'(next_state(s, 1'b1, 16'(PATTERN), PATTERN_W, OVERLAP));
        assign nxt0[s] = N0;
        assign nxt1[s] = N1;
    end

    state_t state_q;
    state_t state_d;
    logic   inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        if (bus.enable) begin
            state_d = state_t'(bus.din ? nxt1[state_q] : nxt0[state_q]);
            inc     = (state_d == S_MATCH);
        end
    end

    // Outputs decode only the state register; din never reaches them directly.
    assign bus.match      = (state_q == S_MATCH);
    assign bus.state_gray = ST_W'(gray(16'(state_q)));

    sat_counter #(
        .W (COUNT_W)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .clear (bus.clear),
        .q     (bus.count),
        .sat   (bus.sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: four detector configurations share one random/directed
// stimulus stream and are compared against a history-based reference model.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic din = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.COUNT_W(8), .ST_W(3)) if0 ();
    seq_detector_param_if #(.COUNT_W(8), .ST_W(3)) if1 ();
    seq_detector_param_if #(.COUNT_W(8), .ST_W(3)) if2 ();
    seq_detector_param_if #(.COUNT_W(2), .ST_W(2)) if3 ();

    assign if0.enable = enable;
    assign if0.din    = din;
    assign if0.clear  = clear;
    assign if1.enable = enable;
    assign if1.din    = din;
    assign if1.clear  = clear;
    assign if2.enable = enable;
    assign if2.din    = din;
    assign if2.clear  = clear;
    assign if3.enable = enable;
    assign if3.din    = din;
    assign if3.clear  = clear;

    seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1100), .OVERLAP(1'b1), .COUNT_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .COUNT_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .COUNT_W(8))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    seq_detector_param #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .COUNT_W(2))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic [3:0] act_match;
    logic [3:0] act_sat;
    logic [7:0] act_cnt  [4];
    logic [2:0] act_gray [4];

    assign act_match   = {if3.match, if2.match, if1.match, if0.match};
    assign act_sat     = {if3.sat, if2.sat, if1.sat, if0.sat};
    assign act_cnt[0]  = if0.count;
    assign act_cnt[1]  = if1.count;
    assign act_cnt[2]  = if2.count;
    assign act_cnt[3]  = 8'(if3.count);
    assign act_gray[0] = if0.state_gray;
    assign act_gray[1] = if1.state_gray;
    assign act_gray[2] = if2.state_gray;
    assign act_gray[3] = 3'(if3.state_gray);

    // Reference configuration, matching the four instances above.
    int          pw [4] = '{4, 4, 4, 2};
    logic [15:0] pv [4] = '{16'hC, 16'hA, 16'hA, 16'h3};
    bit          ov [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          cw [4] = '{8, 8, 8, 2};

    // Bits received since reset (overlap) or since the last match (non-overlap).
    logic [63:0] hist [4];
    int          hlen [4];
    int          cnt  [4];
    int          st   [4];

    typedef struct {
        logic [3:0]      match;
        logic [3:0]      sat;
        logic [3:0][7:0] count;
        logic [3:0][2:0] gray;
    } exp_t;

    exp_t exp_q [$];
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic int longest(input int i);
        int          res;
        logic [63:0] mk;
        res = 0;
        for (int k = 1; k <= pw[i]; k++) begin
            mk = (64'd1 << k) - 64'd1;
            if (k <= hlen[i] && (hist[i] & mk) == (64'(pv[i]) >> (pw[i] - k))) begin
                res = k;
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0;
            hlen[i] = 0;
            cnt[i]  = 0;
            st[i]   = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic d, input logic clr);
        logic [63:0] mask;
        bit          hit;
        for (int i = 0; i < 4; i++) begin
            if (en) begin
                hist[i] = {hist[i][62:0], d};
                if (hlen[i] < 64) hlen[i]++;
                mask = (64'd1 << pw[i]) - 64'd1;
                hit  = (hlen[i] >= pw[i]) && ((hist[i] & mask) == 64'(pv[i]));
                if (hit) begin
                    st[i] = pw[i];
                    if (cnt[i] < (1 << cw[i]) - 1) cnt[i]++;
                    if (!ov[i]) hlen[i] = 0;
                end else begin
                    st[i] = longest(i);
                end
            end
            if (clr) cnt[i] = 0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.match[i] = (st[i] == pw[i]);
            e.sat[i]   = (cnt[i] == (1 << cw[i]) - 1);
            e.count[i] = 8'(cnt[i]);
            e.gray[i]  = 3'(st[i] ^ (st[i] >> 1));
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input logic en, input logic d, input logic clr);
        @(negedge clk);
        rst    = 1'b0;
        enable = en;
        din    = d;
        clear  = clr;
        model_step(en, d, clr);
        push_expected();
    endtask

    // Reset lands between edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        clear  = 1'b0;
        din    = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_rst_match", i, 32'(act_match[i]), 32'd0);
            chk("async_rst_count", i, 32'(act_cnt[i]), 32'd0);
            chk("async_rst_sat", i, 32'(act_sat[i]), 32'd0);
            chk("async_rst_gray", i, 32'(act_gray[i]), 32'd0);
        end
        model_reset();
        push_expected();
        mon_en = 1'b1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int k = n - 1; k >= 0; k--) begin
            drive_cycle(1'b1, b[k], 1'b0);
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got no expectation for output at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk("match", i, 32'(act_match[i]), 32'(e.match[i]));
                    chk("count", i, 32'(act_cnt[i]), 32'(e.count[i]));
                    chk("sat", i, 32'(act_sat[i]), 32'(e.sat[i]));
                    chk("state_gray", i, 32'(act_gray[i]), 32'(e.gray[i]));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        send_bits(16'b1100, 4);
        do_reset();
        send_bits(16'b101010, 6);
        do_reset();
        send_bits(16'b11100, 5);

        do_reset();
        send_bits(16'b111111, 6);
        drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0);
        send_bits(16'b11, 2);
        drive_cycle(1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 50; k++) begin
            drive_cycle(1'b0, 1'(k & 1), 1'b0);
        end

        do_reset();
        send_bits(16'b110, 3);
        do_reset();
        send_bits(16'b1100, 4);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 63) == 0));
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
